instr_fetch_unit: RTL and testbench

//  Instruction-fetch front end that produces the instruction stream the Decode block consumes.
//  - Holds the PC and issues word reads to a synchronous instruction memory (1-cycle read latency).
//  - Buffers the returned words in a small FIFO.
//  - Presents {instr, instr_pc} to Decode over a valid/ready handshake.
//  - Accepts a branch redirect that flushes everything in flight.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 90 +++++++++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, the NOP
// encoding presented while no instruction is available, and FSM states.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory, redirect and Decode-side signals of the
// fetch unit. The master modport is the fetch unit, slave is its environment.
interface instr_fetch_unit_if #(
    parameter int XLEN    = fetch_pkg::XLEN,
    parameter int IMEM_AW = 10
);

    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [XLEN-1:0]    instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface : instr_fetch_unit_if

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instr, pc} entries. Clear has
// priority over push/pop; push on a full FIFO is accepted only with a pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en_s;
    logic             pop_en_s;

    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    // Next-state pointers and occupancy.
    always_comb begin
        pop_en_s  = pop_i && (count_q != CW'(0));
        push_en_s = push_i && ((count_q != CW'(DEPTH)) || pop_en_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_d = inc_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_en_s) begin
                rd_ptr_d = inc_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_en_s && !clear_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, 1-cycle-latency memory reads,
// epoch-tagged return path into a small FIFO, and a valid/ready Decode port.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              IMEM_AW  = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int EW = INSTR_W + XLEN;

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            epoch_q;
    logic            inflight_q;
    logic [XLEN-1:0] req_pc_q;
    logic            req_epoch_q;

    logic            req_s;
    logic            redirect_s;
    logic            push_s;
    logic            deq_s;
    logic            valid_s;
    logic            empty_s;
    logic            full_s;
    logic [CW-1:0]   occ_s;
    logic [CW:0]     demand_s;
    logic [EW-1:0]   head_s;
    logic            unused_status_s;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i ({bus.imem_rdata, req_pc_q}),
        .pop_i   (deq_s),
        .clear_i (redirect_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (occ_s)
    );

    // Issue decision: buffer slots already claimed (stored + in flight) after this cycle's pop.
    always_comb begin
        valid_s    = !empty_s;
        deq_s      = valid_s && bus.instr_ready;
        redirect_s = bus.redirect_valid;
        demand_s   = {1'b0, occ_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq_s};
        if (state_q == ST_RUN) begin
            req_s = (demand_s < (CW + 1)'(FQ_DEPTH));
        end else begin
            req_s = 1'b0;
        end
        // A redirect on the return edge wins over the push; stale epochs are dropped.
        push_s = inflight_q && (req_epoch_q == epoch_q) && !redirect_s;
    end

    // FSM, PC sequencing and in-flight request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            req_pc_q    <= {XLEN{1'b0}};
            req_epoch_q <= 1'b0;
        end else begin
            inflight_q  <= req_s;
            req_pc_q    <= pc_q;
            req_epoch_q <= epoch_q;
            if (redirect_s) begin
                pc_q    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                epoch_q <= ~epoch_q;
                state_q <= ST_FLUSH;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (req_s) begin
                            pc_q <= pc_q + XLEN'(4);
                        end
                    end
                    ST_FLUSH: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Decode-side outputs: NOP and zero PC whenever nothing is buffered.
    always_comb begin
        bus.imem_req    = req_s;
        bus.imem_addr   = pc_q[IMEM_AW+1:2];
        bus.instr_valid = valid_s;
        if (valid_s) begin
            bus.instr    = head_s[EW-1:XLEN];
            bus.instr_pc = head_s[XLEN-1:0];
        end else begin
            bus.instr    = NOP_INSTR;
            bus.instr_pc = {XLEN{1'b0}};
        end
    end

    assign unused_status_s = full_s ^ (^bus.redirect_pc[1:0]);

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed latency/backpressure/
// redirect/wrap/reset scenarios plus randomized ready and redirect traffic.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    logic [31:0] mem [1024];
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    int          delivered;

    instr_fetch_unit_if #(.XLEN(32), .IMEM_AW(10)) bus ();

    instr_fetch_unit #(
        .XLEN     (32),
        .IMEM_AW  (10),
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference stream: every accepted word must be the next sequential PC
    // since reset or the latest redirect, with the matching memory contents.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    = 32'h0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", 64'(bus.instr_valid), 64'd1);
                check_eq("hold_instr", 64'(bus.instr), 64'(prev_instr));
                check_eq("hold_pc", 64'(bus.instr_pc), 64'(prev_pc));
            end
            if (!bus.instr_valid) begin
                check_eq("idle_nop", 64'(bus.instr), 64'(NOP_INSTR));
                check_eq("idle_pc", 64'(bus.instr_pc), 64'd0);
            end else if (bus.instr_ready) begin
                check_eq("deliver_pc", 64'(bus.instr_pc), 64'(exp_pc));
                check_eq("deliver_instr", 64'(bus.instr), 64'(mem[exp_pc[11:2]]));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
            hold_prev  = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
            prev_instr = bus.instr;
            prev_pc    = bus.instr_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc, input logic rdy);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        bus.instr_ready    = rdy;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    task automatic startup_sequence(input string pfx);
        tick();
        check_eq({pfx, "_e1_req"}, 64'(bus.imem_req), 64'd1);
        check_eq({pfx, "_e1_valid"}, 64'(bus.instr_valid), 64'd0);
        tick();
        check_eq({pfx, "_e2_valid"}, 64'(bus.instr_valid), 64'd0);
        tick();
        check_eq({pfx, "_e3_valid"}, 64'(bus.instr_valid), 64'd1);
        check_eq({pfx, "_e3_pc"}, 64'(bus.instr_pc), 64'd0);
        check_eq({pfx, "_e3_instr"}, 64'(bus.instr), 64'(mem[0]));
    endtask

    initial begin
        logic [31:0] pc_hold;
        int          d0;
        tests_run          = 0;
        tests_failed       = 0;
        delivered          = 0;
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // T1: reset values and first-fetch latency
        repeat (3) tick();
        check_eq("rst_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("rst_req", 64'(bus.imem_req), 64'd0);
        check_eq("rst_instr", 64'(bus.instr), 64'(NOP_INSTR));
        check_eq("rst_pc", 64'(bus.instr_pc), 64'd0);
        rst_n = 1'b1;
        startup_sequence("t1");

        // T2: streaming without bubbles
        bus.instr_ready = 1'b1;
        repeat (8) begin
            tick();
            check_eq("t2_nobubble", 64'(bus.instr_valid), 64'd1);
        end

        // T3: backpressure
        bus.instr_ready = 1'b0;
        pc_hold = bus.instr_pc;
        repeat (5) tick();
        check_eq("t3_req_stop", 64'(bus.imem_req), 64'd0);
        check_eq("t3_occ", 64'(dut.u_fifo.count_o), 64'd2);
        check_eq("t3_pc_stable", 64'(bus.instr_pc), 64'(pc_hold));
        bus.instr_ready = 1'b1;
        repeat (6) tick();

        // T4: redirect with a read in flight
        pulse_redirect(32'h0000_0102, 1'b0);
        check_eq("t4_r0_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        check_eq("t4_r1_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        check_eq("t4_r2_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        check_eq("t4_r3_valid", 64'(bus.instr_valid), 64'd1);
        check_eq("t4_pc", 64'(bus.instr_pc), 64'h100);
        check_eq("t4_instr", 64'(bus.instr), 64'(mem[64]));
        bus.instr_ready = 1'b1;
        repeat (4) tick();

        // T5: memory address wrap
        pulse_redirect(32'h0000_0FFC, 1'b0);
        tick();
        check_eq("t5_addr_top", 64'(bus.imem_addr), 64'd1023);
        check_eq("t5_req_top", 64'(bus.imem_req), 64'd1);
        tick();
        check_eq("t5_addr_wrap", 64'(bus.imem_addr), 64'd0);
        tick();
        check_eq("t5_pc_ffc", 64'(bus.instr_pc), 64'hFFC);
        bus.instr_ready = 1'b1;
        tick();
        check_eq("t5_pc_1000", 64'(bus.instr_pc), 64'h1000);
        check_eq("t5_instr_wrap", 64'(bus.instr), 64'(mem[0]));
        repeat (4) tick();

        // T6a: redirect on the same edge as a handshake
        check_eq("t6_pre_valid", 64'(bus.instr_valid), 64'd1);
        d0 = delivered;
        pulse_redirect(32'h0000_0200, 1'b1);
        check_eq("t6_popped", 64'(delivered), 64'(d0 + 1));
        check_eq("t6_flushed", 64'(bus.instr_valid), 64'd0);
        repeat (3) tick();
        check_eq("t6_restart_pc", 64'(bus.instr_pc), 64'h200);
        repeat (4) tick();

        // T6b: asynchronous reset mid-stream, restart as after power-up
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", 64'(bus.instr_valid), 64'd0);
        check_eq("t6_async_instr", 64'(bus.instr), 64'(NOP_INSTR));
        check_eq("t6_async_req", 64'(bus.imem_req), 64'd0);
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        startup_sequence("t6r");

        // Randomized ready and redirect traffic
        d0 = delivered;
        for (int n = 0; n < 3000; n++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
                bus.redirect_pc    = 32'h0;
            end
            tick();
        end
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        repeat (10) tick();
        check_eq("rand_progress", 64'(delivered > d0 + 1000), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_instr_fetch_unit
